// File: rtl/v2p_req_dispatch.sv
// Steers the CEU V2P write-request stream to the ICM, MPT or MTT sub-engine by head type,
// through a single retiming register; unknown-type packets are swallowed and counted.
module v2p_req_dispatch #(
    parameter int                DATA_W   = 256,
    parameter int                HEAD_W   = 128,
    parameter int                TYPE_W   = 4,
    parameter logic [TYPE_W-1:0] ICM_TYPE = TYPE_W'(1),
    parameter logic [TYPE_W-1:0] MPT_TYPE = TYPE_W'(2),
    parameter logic [TYPE_W-1:0] MTT_TYPE = TYPE_W'(3)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data,
    input  logic [HEAD_W-1:0] in_head,
    output logic              in_ready,
    output logic              icm_valid,
    output logic              icm_last,
    output logic [DATA_W-1:0] icm_data,
    output logic [HEAD_W-1:0] icm_head,
    input  logic              icm_ready,
    output logic              mpt_valid,
    output logic              mpt_last,
    output logic [DATA_W-1:0] mpt_data,
    output logic [HEAD_W-1:0] mpt_head,
    input  logic              mpt_ready,
    output logic              mtt_valid,
    output logic              mtt_last,
    output logic [DATA_W-1:0] mtt_data,
    output logic [HEAD_W-1:0] mtt_head,
    input  logic              mtt_ready,
    output logic              err_pulse,
    output logic [15:0]       err_cnt
);

    typedef enum logic [1:0] {ST_SOP, ST_FWD, ST_DROP} state_t;
    typedef enum logic [1:0] {DST_ICM, DST_MPT, DST_MTT, DST_NONE} dst_t;

    function automatic dst_t decode_type(input logic [TYPE_W-1:0] t);
        if (t == ICM_TYPE)      return DST_ICM;
        else if (t == MPT_TYPE) return DST_MPT;
        else if (t == MTT_TYPE) return DST_MTT;
        else                    return DST_NONE;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t            state_q, state_d;
    dst_t              lock_q, lock_d;
    dst_t              in_dst, push_dst;
    logic              known, push, pop, sel_ready, err_ev;

    logic              vld_p1;
    logic              last_p1;
    logic [DATA_W-1:0] data_p1;
    logic [HEAD_W-1:0] head_p1;
    dst_t              dst_p1;

    assign in_dst = decode_type(in_head[HEAD_W-1 -: TYPE_W]);
    assign known  = (in_dst != DST_NONE);

    always_comb begin
        case (dst_p1)
            DST_ICM: sel_ready = icm_ready;
            DST_MPT: sel_ready = mpt_ready;
            DST_MTT: sel_ready = mtt_ready;
            default: sel_ready = 1'b0;
        endcase
    end

    assign pop      = vld_p1 & sel_ready;
    assign in_ready = (state_q == ST_DROP) | ((state_q == ST_SOP) & ~known) | ~vld_p1 | pop;

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        push     = 1'b0;
        push_dst = lock_q;
        err_ev   = 1'b0;
        case (state_q)
            ST_SOP: begin
                push_dst = in_dst;
                if (in_valid && in_ready) begin
                    if (known) begin
                        push    = 1'b1;
                        lock_d  = in_dst;
                        state_d = in_last ? ST_SOP : ST_FWD;
                    end else begin
                        err_ev  = 1'b1;
                        state_d = in_last ? ST_SOP : ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (in_valid && in_ready) begin
                    push = 1'b1;
                    if (in_last) state_d = ST_SOP;
                end
            end
            ST_DROP: begin
                if (in_valid && in_last) state_d = ST_SOP;
            end
            default: state_d = ST_SOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SOP;
            lock_q    <= DST_ICM;
            vld_p1    <= 1'b0;
            dst_p1    <= DST_ICM;
            err_pulse <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            vld_p1    <= push | (vld_p1 & ~pop);
            if (push) dst_p1 <= push_dst;
            err_pulse <= err_ev;
            if (err_ev) err_cnt <= sat_inc(err_cnt);
        end
    end

    // Stage p1: retimed beat; payload needs no reset because every output is gated by vld_p1
    always_ff @(posedge clk) begin
        if (push) begin
            last_p1 <= in_last;
            data_p1 <= in_data;
            head_p1 <= in_head;
        end
    end

    assign icm_valid = vld_p1 & (dst_p1 == DST_ICM);
    assign mpt_valid = vld_p1 & (dst_p1 == DST_MPT);
    assign mtt_valid = vld_p1 & (dst_p1 == DST_MTT);

    assign icm_last  = icm_valid & last_p1;
    assign mpt_last  = mpt_valid & last_p1;
    assign mtt_last  = mtt_valid & last_p1;

    assign icm_data  = icm_valid ? data_p1 : '0;
    assign mpt_data  = mpt_valid ? data_p1 : '0;
    assign mtt_data  = mtt_valid ? data_p1 : '0;

    assign icm_head  = icm_valid ? head_p1 : '0;
    assign mpt_head  = mpt_valid ? head_p1 : '0;
    assign mtt_head  = mtt_valid ? head_p1 : '0;

endmodule

// File: tb/tb_v2p_req_dispatch.sv
// Bench for v2p_req_dispatch: table vectors, directed corner sequences, and random traffic
// checked against a per-channel packet queue model.
module tb_v2p_req_dispatch;
    localparam int DW = 256;
    localparam int HW = 128;
    localparam int TW = 4;
    localparam logic [TW-1:0] T_ICM = 4'd1;
    localparam logic [TW-1:0] T_MPT = 4'd2;
    localparam logic [TW-1:0] T_MTT = 4'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_last, in_ready;
    logic [DW-1:0] in_data;
    logic [HW-1:0] in_head;
    logic          icm_valid, icm_last, icm_ready;
    logic [DW-1:0] icm_data;
    logic [HW-1:0] icm_head;
    logic          mpt_valid, mpt_last, mpt_ready;
    logic [DW-1:0] mpt_data;
    logic [HW-1:0] mpt_head;
    logic          mtt_valid, mtt_last, mtt_ready;
    logic [DW-1:0] mtt_data;
    logic [HW-1:0] mtt_head;
    logic          err_pulse;
    logic [15:0]   err_cnt;

    v2p_req_dispatch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_head(in_head), .in_ready(in_ready),
        .icm_valid(icm_valid), .icm_last(icm_last), .icm_data(icm_data), .icm_head(icm_head), .icm_ready(icm_ready),
        .mpt_valid(mpt_valid), .mpt_last(mpt_last), .mpt_data(mpt_data), .mpt_head(mpt_head), .mpt_ready(mpt_ready),
        .mtt_valid(mtt_valid), .mtt_last(mtt_last), .mtt_data(mtt_data), .mtt_head(mtt_head), .mtt_ready(mtt_ready),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          v;
        logic          last;
        logic [TW-1:0] typ;
        logic [31:0]   d;
        logic          e_icm, e_mpt, e_mtt, e_rdy, e_err;
        logic [31:0]   e_d;
    } vec_t;
    vec_t tbl[11];

    typedef struct {
        logic [DW-1:0] d;
        logic [HW-1:0] h;
        logic          l;
    } exp_t;
    exp_t q_icm[$];
    exp_t q_mpt[$];
    exp_t q_mtt[$];

    function automatic logic [HW-1:0] mk_head(input logic [TW-1:0] t, input logic [63:0] lo);
        logic [HW-1:0] h;
        h = '0;
        h[HW-1 -: TW] = t;
        h[63:0] = lo;
        return h;
    endfunction

    function automatic bit is_known(input logic [TW-1:0] t);
        return (t == T_ICM) || (t == T_MPT) || (t == T_MTT);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic [TW-1:0] t,
                         input logic [63:0] lo, input logic [DW-1:0] d);
        in_valid = v;
        in_last  = l;
        in_head  = mk_head(t, lo);
        in_data  = d;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop(input int ch, input logic [DW-1:0] d, input logic [HW-1:0] h, input logic l);
        exp_t e;
        int   sz;
        case (ch)
            0:       sz = q_icm.size();
            1:       sz = q_mpt.size();
            default: sz = q_mtt.size();
        endcase
        chk($sformatf("pop_avail_ch%0d", ch), DW'(sz != 0), DW'(1));
        if (sz != 0) begin
            case (ch)
                0:       e = q_icm.pop_front();
                1:       e = q_mpt.pop_front();
                default: e = q_mtt.pop_front();
            endcase
            chk($sformatf("pop_data_ch%0d", ch), d, e.d);
            chk($sformatf("pop_head_ch%0d", ch), DW'(h), DW'(e.h));
            chk($sformatf("pop_last_ch%0d", ch), DW'(l), DW'(e.l));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, DW'({icm_valid, mpt_valid, mtt_valid}), '0);
        chk({tag, "_last"},  DW'({icm_last, mpt_last, mtt_last}), '0);
        chk({tag, "_data"},  icm_data | mpt_data | mtt_data, '0);
        chk({tag, "_head"},  DW'(icm_head | mpt_head | mtt_head), '0);
        chk({tag, "_err_pulse"}, DW'(err_pulse), '0);
        chk({tag, "_err_cnt"},   DW'(err_cnt), '0);
    endtask

    // random-phase state
    logic          gen_v, gen_l, taken, exp_pulse, m_in_pkt, done;
    logic [TW-1:0] gen_t, m_route;
    logic [HW-1:0] gen_h;
    logic [DW-1:0] gen_d;
    int            rem, m_err, tsel;
    logic          p_icm_v, p_icm_r, p_mpt_v, p_mpt_r, p_mtt_v, p_mtt_r;
    logic [DW-1:0] p_icm_d, p_mpt_d, p_mtt_d;
    exp_t          e_new;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, '0);
        icm_ready = 1; mpt_ready = 1; mtt_ready = 1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("reset_in_ready", DW'(in_ready), DW'(1));
        next_cycle();

        // back-to-back routing and unknown-type drain
        tbl[0]  = '{1, 1, T_ICM, 32'd1, 0, 0, 0, 1, 0, 32'd0};
        tbl[1]  = '{1, 1, T_MPT, 32'd2, 1, 0, 0, 1, 0, 32'd1};
        tbl[2]  = '{1, 1, T_MTT, 32'd3, 0, 1, 0, 1, 0, 32'd2};
        tbl[3]  = '{1, 1, T_ICM, 32'd4, 0, 0, 1, 1, 0, 32'd3};
        tbl[4]  = '{0, 0, 4'd0,  32'd0, 1, 0, 0, 1, 0, 32'd4};
        tbl[5]  = '{0, 0, 4'd0,  32'd0, 0, 0, 0, 1, 0, 32'd0};
        tbl[6]  = '{1, 0, 4'd0,  32'd5, 0, 0, 0, 1, 0, 32'd0};
        tbl[7]  = '{1, 0, T_ICM, 32'd6, 0, 0, 0, 1, 1, 32'd0};
        tbl[8]  = '{1, 1, T_MPT, 32'd7, 0, 0, 0, 1, 0, 32'd0};
        tbl[9]  = '{1, 1, T_ICM, 32'd8, 0, 0, 0, 1, 0, 32'd0};
        tbl[10] = '{0, 0, 4'd0,  32'd0, 1, 0, 0, 1, 0, 32'd8};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].last, tbl[i].typ, 64'(tbl[i].d), DW'(tbl[i].d));
            @(negedge clk);
            chk($sformatf("tbl%0d_icm_valid", i), DW'(icm_valid), DW'(tbl[i].e_icm));
            chk($sformatf("tbl%0d_mpt_valid", i), DW'(mpt_valid), DW'(tbl[i].e_mpt));
            chk($sformatf("tbl%0d_mtt_valid", i), DW'(mtt_valid), DW'(tbl[i].e_mtt));
            chk($sformatf("tbl%0d_in_ready", i),  DW'(in_ready),  DW'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_err_pulse", i), DW'(err_pulse), DW'(tbl[i].e_err));
            chk($sformatf("tbl%0d_data", i), icm_data | mpt_data | mtt_data, DW'(tbl[i].e_d));
            next_cycle();
        end
        @(negedge clk);
        chk("unknown_err_cnt", DW'(err_cnt), DW'(1));
        next_cycle();

        // MTT 2-beat packet
        drive(1, 0, T_MTT, 64'h10, DW'(256'hA1));
        @(negedge clk);
        chk("mtt2_ready", DW'(in_ready), DW'(1));
        next_cycle();
        drive(1, 1, T_MTT, 64'h10, DW'(256'hA2));
        @(negedge clk);
        chk("mtt2_b0_valid", DW'({icm_valid, mpt_valid, mtt_valid}), DW'(3'b001));
        chk("mtt2_b0_last", DW'(mtt_last), DW'(0));
        chk("mtt2_b0_data", mtt_data, DW'(256'hA1));
        chk("mtt2_b0_head", DW'(mtt_head), DW'(mk_head(T_MTT, 64'h10)));
        next_cycle();
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("mtt2_b1_valid", DW'({icm_valid, mpt_valid, mtt_valid}), DW'(3'b001));
        chk("mtt2_b1_last", DW'(mtt_last), DW'(1));
        chk("mtt2_b1_data", mtt_data, DW'(256'hA2));
        chk("mtt2_b1_head", DW'(mtt_head), DW'(mk_head(T_MTT, 64'h10)));
        next_cycle();
        @(negedge clk);
        chk("mtt2_after_valid", DW'(mtt_valid), DW'(0));
        next_cycle();

        // Backpressure on MPT
        mpt_ready = 0;
        drive(1, 1, T_MPT, 64'h20, DW'(256'hC0));
        @(negedge clk);
        chk("bp_first_ready", DW'(in_ready), DW'(1));
        next_cycle();
        drive(1, 1, T_MPT, 64'h21, DW'(256'hD0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", i), DW'(mpt_valid), DW'(1));
            chk($sformatf("bp_hold%0d_data", i), mpt_data, DW'(256'hC0));
            chk($sformatf("bp_hold%0d_ready", i), DW'(in_ready), DW'(0));
            next_cycle();
        end
        mpt_ready = 1;
        @(negedge clk);
        chk("bp_release_data", mpt_data, DW'(256'hC0));
        chk("bp_release_ready", DW'(in_ready), DW'(1));
        next_cycle();
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("bp_second_valid", DW'(mpt_valid), DW'(1));
        chk("bp_second_data", mpt_data, DW'(256'hD0));
        next_cycle();
        @(negedge clk);
        chk("bp_empty", DW'(mpt_valid), DW'(0));
        next_cycle();

        // Reset mid-packet
        drive(1, 0, T_MTT, 64'h30, DW'(256'hE0));
        next_cycle();
        drive(0, 0, 0, 0, '0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        drive(1, 1, T_ICM, 64'h40, DW'(256'hF0));
        @(negedge clk);
        chk("midrst_ready", DW'(in_ready), DW'(1));
        next_cycle();
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("midrst_route", DW'({icm_valid, mpt_valid, mtt_valid}), DW'(3'b100));
        chk("midrst_data", icm_data, DW'(256'hF0));
        next_cycle();

        // Random traffic against the queue model
        gen_v = 0; gen_l = 0; gen_t = 0; gen_h = '0; gen_d = '0; rem = 0; taken = 1;
        exp_pulse = 0; m_in_pkt = 0; m_route = 0; m_err = 0; done = 0;
        p_icm_v = 0; p_icm_r = 0; p_mpt_v = 0; p_mpt_r = 0; p_mtt_v = 0; p_mtt_r = 0;
        p_icm_d = '0; p_mpt_d = '0; p_mtt_d = '0;
        for (int cyc = 0; cyc < 3300; cyc++) begin
            if (taken || !gen_v) begin
                if ((cyc < 3000) ? ($urandom_range(0, 3) != 0) : (rem != 0)) begin
                    if (rem == 0) begin
                        rem  = $urandom_range(1, 4);
                        tsel = $urandom_range(0, 4);
                        gen_t = (tsel == 4) ? 4'd7 : TW'(tsel);
                        gen_h = {$urandom, $urandom, $urandom, $urandom};
                        gen_h[HW-1 -: TW] = gen_t;
                    end else if ($urandom_range(0, 3) == 0) begin
                        gen_h[HW-1 -: TW] = TW'($urandom_range(0, 7));
                    end
                    gen_d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    rem--;
                    gen_l = (rem == 0);
                    gen_v = 1;
                end else begin
                    gen_v = 0;
                end
            end
            in_valid = gen_v; in_last = gen_l; in_head = gen_h; in_data = gen_d;
            if (cyc < 3000) begin
                icm_ready = ($urandom_range(0, 9) < 7);
                mpt_ready = ($urandom_range(0, 9) < 7);
                mtt_ready = ($urandom_range(0, 9) < 7);
            end else begin
                icm_ready = 1; mpt_ready = 1; mtt_ready = 1;
            end
            @(negedge clk);
            chk("rnd_onehot", DW'($countones({icm_valid, mpt_valid, mtt_valid}) <= 1), DW'(1));
            chk("rnd_err_pulse", DW'(err_pulse), DW'(exp_pulse));
            if (p_icm_v && !p_icm_r) chk("rnd_icm_hold", {icm_valid, icm_data[DW-2:0]}, {1'b1, p_icm_d[DW-2:0]});
            if (p_mpt_v && !p_mpt_r) chk("rnd_mpt_hold", {mpt_valid, mpt_data[DW-2:0]}, {1'b1, p_mpt_d[DW-2:0]});
            if (p_mtt_v && !p_mtt_r) chk("rnd_mtt_hold", {mtt_valid, mtt_data[DW-2:0]}, {1'b1, p_mtt_d[DW-2:0]});
            if (icm_valid && icm_ready) check_pop(0, icm_data, icm_head, icm_last);
            if (mpt_valid && mpt_ready) check_pop(1, mpt_data, mpt_head, mpt_last);
            if (mtt_valid && mtt_ready) check_pop(2, mtt_data, mtt_head, mtt_last);
            p_icm_v = icm_valid; p_icm_r = icm_ready; p_icm_d = icm_data;
            p_mpt_v = mpt_valid; p_mpt_r = mpt_ready; p_mpt_d = mpt_data;
            p_mtt_v = mtt_valid; p_mtt_r = mtt_ready; p_mtt_d = mtt_data;

            exp_pulse = 0;
            if (gen_v && (m_in_pkt ? (m_route == 0) : !is_known(gen_h[HW-1 -: TW])))
                chk("rnd_drop_ready", DW'(in_ready), DW'(1));
            taken = gen_v && in_ready;
            if (taken) begin
                if (!m_in_pkt) begin
                    m_route = is_known(gen_h[HW-1 -: TW]) ? gen_h[HW-1 -: TW] : 4'd0;
                    if (m_route == 0) begin
                        m_err++;
                        exp_pulse = 1;
                    end
                end
                if (m_route != 0) begin
                    e_new.d = gen_d; e_new.h = gen_h; e_new.l = gen_l;
                    case (m_route)
                        T_ICM:   q_icm.push_back(e_new);
                        T_MPT:   q_mpt.push_back(e_new);
                        default: q_mtt.push_back(e_new);
                    endcase
                end
                m_in_pkt = !gen_l;
            end
            if (cyc >= 3000 && rem == 0 && !gen_v && q_icm.size() == 0 && q_mpt.size() == 0 &&
                q_mtt.size() == 0 && !icm_valid && !mpt_valid && !mtt_valid) begin
                done = 1;
                break;
            end
            next_cycle();
        end
        chk("rnd_drained", DW'(done), DW'(1));
        drive(0, 0, 0, 0, '0);
        next_cycle();
        @(negedge clk);
        chk("rnd_err_cnt", DW'(err_cnt), DW'(16'(m_err)));
        next_cycle();

        // Saturation of the drop counter
        drive(1, 1, 4'd0, 64'h0, '0);
        repeat (65540) @(posedge clk);
        #1;
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        chk("sat_err_cnt", DW'(err_cnt), DW'(16'hFFFF));
        chk("sat_no_valid", DW'({icm_valid, mpt_valid, mtt_valid}), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
